wave_sampler: RTL

WAVE_SAMPLER -- requirements
Module: wave_sampler

---
 rtl/wave_sampler.sv | 124 ++++++++++++
 1 files changed

// File: rtl/wave_sampler.sv
// Captures one 256-sample audio frame per positive zero crossing into a ping-pong RAM.
// Optional macro WAVE_SAMPLER_DECIMATE_EN accepts only every other sample strobe.
module wave_sampler (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        new_sample_ready,
   input  logic [15:0] new_sample_in,
   input  logic        wave_display_idle,
   output logic [8:0]  write_address,
   output logic        write_enable,
   output logic [7:0]  write_sample,
   output logic        read_index
);

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_e;

   state_e      state_q, state_d;
   logic [7:0]  offset_q, offset_d;
   logic [15:0] prev_q, prev_d;
   logic        read_index_q, read_index_d;
   logic        we_q, we_d;
   logic [8:0]  addr_q, addr_d;
   logic [7:0]  data_q, data_d;
   logic        accept;
   logic [7:0]  sample_ob;

`ifdef WAVE_SAMPLER_DECIMATE_EN
   logic phase_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         phase_q <= 1'b0;
      end else if (new_sample_ready) begin
         phase_q <= ~phase_q;
      end
   end

   assign accept = new_sample_ready & ~phase_q;
`else
   assign accept = new_sample_ready;
`endif

   // Flip the sign bit to turn two's complement into offset binary.
   assign sample_ob = {~new_sample_in[15], new_sample_in[14:8]};

   // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d      = state_q;
      offset_d     = offset_q;
      prev_d       = prev_q;
      read_index_d = read_index_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      data_d       = data_q;

      if (accept) begin
         prev_d = new_sample_in;
      end

      case (state_q)
         ST_ARMED: begin
            if (accept && prev_q[15] && !new_sample_in[15]) begin
               we_d     = 1'b1;
               addr_d   = {~read_index_q, 8'd0};
               data_d   = sample_ob;
               offset_d = 8'd1;
               state_d  = ST_ACTIVE;
            end
         end
         ST_ACTIVE: begin
            if (accept) begin
               we_d     = 1'b1;
               addr_d   = {~read_index_q, offset_q};
               data_d   = sample_ob;
               offset_d = offset_q + 8'd1;
               if (offset_q == 8'hFF) begin
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (wave_display_idle) begin
               read_index_d = ~read_index_q;
               offset_d     = 8'd0;
               state_d      = ST_ARMED;
            end
         end
         default: begin
            state_d = ST_ARMED;
         end
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_ARMED;
         offset_q     <= 8'd0;
         prev_q       <= 16'd0;
         read_index_q <= 1'b0;
         we_q         <= 1'b0;
         addr_q       <= 9'd0;
         data_q       <= 8'd0;
      end else begin
         state_q      <= state_d;
         offset_q     <= offset_d;
         prev_q       <= prev_d;
         read_index_q <= read_index_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         data_q       <= data_d;
      end
   end

   assign write_enable  = we_q;
   assign write_address = addr_q;
   assign write_sample  = data_q;
   assign read_index    = read_index_q;

endmodule
